// File: rtl/openmips_pkg.sv
// Shared arbiter types and bus constants for the fetch/data memory path.
// RegBus/ZeroWord fall back to local definitions when defines.sv is not in the build.
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h00000000
`endif

package openmips_pkg;

    typedef logic [`RegBus] word_t;

    localparam word_t      BUS_ZERO = `ZeroWord;
    localparam logic [3:0] SEL_ALL  = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        IBUS,
        DBUS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } arb_owner_t;

endpackage

// File: rtl/bus_watchdog.sv
// Counts bus cycles without acknowledge; expire_o flags the last allowed cycle.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single external memory bus shared by fetch and MEM-stage ports; data port wins,
// one transaction at a time, with per-port stall requests and a hang watchdog.
module mem_bus_arbiter
    import openmips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ce_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_data_o,
    output logic        inst_stallreq_o,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_sel_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_stallreq_o,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o,
    output logic [31:0] err_addr_o
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    logic       drop_q, drop_d;
    logic       bus_req_q, bus_req_d, bus_we_q, bus_we_d, bus_err_q, bus_err_d;
    logic [3:0] bus_sel_q, bus_sel_d;
    word_t      bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    word_t      inst_data_q, inst_data_d, data_rdata_q, data_rdata_d;
    word_t      err_addr_q, err_addr_d;

    logic in_bus, wd_expire, dropped;

    assign in_bus = (state_q == IBUS) || (state_q == DBUS);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == IDLE),
        .en_i     (in_bus && !bus_ack_i),
        .expire_o (wd_expire)
    );

    // A flush arriving in the completing cycle already counts as a drop.
    assign dropped = (state_q == IBUS) && (drop_q || flush_i);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        drop_d       = drop_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_sel_d    = bus_sel_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_data_d  = inst_data_q;
        data_rdata_d = data_rdata_q;
        err_addr_d   = err_addr_q;
        bus_err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (data_ce_i) begin
                    state_d     = DBUS;
                    owner_d     = OWN_DATA;
                    bus_req_d   = 1'b1;
                    bus_we_d    = data_we_i;
                    bus_sel_d   = data_sel_i;
                    bus_addr_d  = data_addr_i;
                    bus_wdata_d = data_wdata_i;
                end else if (inst_ce_i && !flush_i) begin
                    state_d     = IBUS;
                    owner_d     = OWN_INST;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = SEL_ALL;
                    bus_addr_d  = inst_addr_i;
                    bus_wdata_d = BUS_ZERO;
                end
            end
            IBUS, DBUS: begin
                drop_d = dropped;
                if (bus_ack_i || wd_expire) begin
                    bus_req_d = 1'b0;
                    if (!bus_ack_i) begin
                        bus_err_d  = 1'b1;
                        err_addr_d = bus_addr_q;
                    end
                    if (dropped) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = RESP;
                        if (owner_q == OWN_INST) begin
                            inst_data_d = bus_ack_i ? bus_rdata_i : BUS_ZERO;
                        end else begin
                            data_rdata_d = bus_ack_i ? bus_rdata_i : BUS_ZERO;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INST;
            drop_q       <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_data_q  <= '0;
            data_rdata_q <= '0;
            err_addr_q   <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_sel_q    <= bus_sel_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_data_q  <= inst_data_d;
            data_rdata_q <= data_rdata_d;
            err_addr_q   <= err_addr_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign inst_stallreq_o = inst_ce_i && !flush_i
                             && !((state_q == RESP) && (owner_q == OWN_INST));
    assign data_stallreq_o = data_ce_i
                             && !((state_q == RESP) && (owner_q == OWN_DATA));

    assign inst_data_o  = inst_data_q;
    assign data_rdata_o = data_rdata_q;
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_sel_o    = bus_sel_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign bus_err_o    = bus_err_q;
    assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected read data queued per port at request
// time, popped when the port's stall drops while its request is held.
module tb_mem_bus_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ce_i, data_ce_i, data_we_i, flush_i, bus_ack_i;
    logic [3:0]  data_sel_i;
    logic [31:0] inst_addr_i, data_addr_i, data_wdata_i, bus_rdata_i;
    logic [31:0] inst_data_o, data_rdata_o, bus_addr_o, bus_wdata_o, err_addr_o;
    logic        inst_stallreq_o, data_stallreq_o, bus_req_o, bus_we_o, bus_err_o;
    logic [3:0]  bus_sel_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT (TO),
        .CNT_W   (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_ce_i       (inst_ce_i),
        .inst_addr_i     (inst_addr_i),
        .inst_data_o     (inst_data_o),
        .inst_stallreq_o (inst_stallreq_o),
        .data_ce_i       (data_ce_i),
        .data_we_i       (data_we_i),
        .data_sel_i      (data_sel_i),
        .data_addr_i     (data_addr_i),
        .data_wdata_i    (data_wdata_i),
        .data_rdata_o    (data_rdata_o),
        .data_stallreq_o (data_stallreq_o),
        .flush_i         (flush_i),
        .bus_req_o       (bus_req_o),
        .bus_we_o        (bus_we_o),
        .bus_sel_o       (bus_sel_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_ack_i       (bus_ack_i),
        .bus_rdata_i     (bus_rdata_i),
        .bus_err_o       (bus_err_o),
        .err_addr_o      (err_addr_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned inst_stall_cyc = 0;
    int unsigned data_stall_cyc = 0;
    int unsigned err_pulses     = 0;
    logic [31:0] inst_q[$];
    logic [31:0] data_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                if (data_stallreq_o) data_stall_cyc++;
                if (inst_stallreq_o) inst_stall_cyc++;
                if (bus_err_o)       err_pulses++;
                if (data_ce_i && !data_stallreq_o) begin
                    check_eq("data_resp_expected", 32'(data_q.size() != 0), 32'd1);
                    if (data_q.size() != 0) check_eq("data_rdata", data_rdata_o, data_q.pop_front());
                end
                if (inst_ce_i && !flush_i && !inst_stallreq_o) begin
                    check_eq("inst_resp_expected", 32'(inst_q.size() != 0), 32'd1);
                    if (inst_q.size() != 0) check_eq("inst_data", inst_data_o, inst_q.pop_front());
                end
            end
        end
    endtask

    // Wait for the bus strobe, check the presented request every cycle, ack after 'waits'.
    task automatic serve(input string tag, input logic [31:0] addr, input logic we,
                         input logic [3:0] sel, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int unsigned waits);
        int unsigned budget = 0;
        @(negedge clk);
        while (!bus_req_o && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check_eq({tag, "_req"}, 32'(bus_req_o), 32'd1);
        if (!bus_req_o) return;
        for (int unsigned w = 0; w <= waits; w++) begin
            if (w != 0) @(negedge clk);
            check_eq({tag, "_req_held"}, 32'(bus_req_o), 32'd1);
            check_eq({tag, "_addr"}, bus_addr_o, addr);
            check_eq({tag, "_we"}, 32'(bus_we_o), 32'(we));
            check_eq({tag, "_sel"}, 32'(bus_sel_o), 32'(sel));
            if (we) check_eq({tag, "_wdata"}, bus_wdata_o, wdata);
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = rdata;
        step();
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
    endtask

    task automatic access(input string tag, input logic is_data, input logic [31:0] addr,
                          input logic [31:0] rdata, input int unsigned waits);
        int unsigned s0;
        s0 = is_data ? data_stall_cyc : inst_stall_cyc;
        if (is_data) begin
            data_ce_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'hF; data_addr_i = addr;
            data_q.push_back(rdata);
        end else begin
            inst_ce_i = 1'b1; inst_addr_i = addr;
            inst_q.push_back(rdata);
        end
        serve(tag, addr, 1'b0, 4'hF, 32'h0, rdata, waits);
        @(negedge clk);
        check_eq({tag, "_resp_req_low"}, 32'(bus_req_o), 32'd0);
        #1;
        data_ce_i = 1'b0;
        inst_ce_i = 1'b0;
        step();
        check_eq({tag, "_stall_cycles"},
                 (is_data ? data_stall_cyc : inst_stall_cyc) - s0, 2 + waits);
        check_eq({tag, "_q_drained"}, 32'(is_data ? data_q.size() : inst_q.size()), 32'd0);
    endtask

    task automatic run_tests();
        int unsigned s_i, s_d, e0, budget;

        rst = 1'b0; inst_ce_i = 1'b0; data_ce_i = 1'b0; data_we_i = 1'b0; flush_i = 1'b0;
        bus_ack_i = 1'b0; data_sel_i = '0; inst_addr_i = '0; data_addr_i = '0;
        data_wdata_i = '0; bus_rdata_i = '0;
        repeat (3) step();
        check_eq("rst_bus_req", 32'(bus_req_o), 32'd0);
        check_eq("rst_bus_addr", bus_addr_o, 32'h0);
        check_eq("rst_err_addr", err_addr_o, 32'h0);
        check_eq("rst_stalls", 32'({inst_stallreq_o, data_stallreq_o}), 32'd0);
        rst = 1'b1;
        step();

        // Fastest load: two stall cycles, strobe for one cycle.
        access("load", 1'b1, 32'h100, 32'hDEADBEEF, 0);

        // Simultaneous store and fetch: store owns the bus first.
        s_i = inst_stall_cyc; s_d = data_stall_cyc;
        inst_ce_i = 1'b1; inst_addr_i = 32'h0;
        data_ce_i = 1'b1; data_we_i = 1'b1; data_sel_i = 4'hF;
        data_addr_i = 32'h200; data_wdata_i = 32'h12345678;
        data_q.push_back(32'hC0FFEE00);
        inst_q.push_back(32'h00000013);
        serve("store", 32'h200, 1'b1, 4'hF, 32'h12345678, 32'hC0FFEE00, 0);
        @(negedge clk); #1;
        data_ce_i = 1'b0; data_we_i = 1'b0;
        serve("fetch", 32'h0, 1'b0, 4'hF, 32'h0, 32'h00000013, 0);
        @(negedge clk); #1;
        inst_ce_i = 1'b0;
        step();
        check_eq("cont_data_stall", data_stall_cyc - s_d, 32'd2);
        check_eq("cont_inst_stall", inst_stall_cyc - s_i, 32'd5);

        // Three wait states; ack lands on the watchdog's last cycle and must win.
        e0 = err_pulses;
        access("wait3", 1'b1, 32'h104, 32'h11223344, 3);
        check_eq("wait3_no_err", err_pulses - e0, 32'd0);

        // Flush during a fetch: bus runs to ack, no response, fetch data untouched.
        inst_ce_i = 1'b1; inst_addr_i = 32'h80;
        @(negedge clk);
        step();
        @(negedge clk);
        check_eq("flush_ibus_req", 32'(bus_req_o), 32'd1);
        #1 flush_i = 1'b1;
        #1 check_eq("flush_forces_stall_low", 32'(inst_stallreq_o), 32'd0);
        step();
        flush_i = 1'b0;
        @(negedge clk);
        check_eq("flush_still_stalled", 32'(inst_stallreq_o), 32'd1);
        check_eq("flush_addr_held", bus_addr_o, 32'h80);
        @(negedge clk); #1;
        bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA5555; inst_ce_i = 1'b0;
        step();
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        @(negedge clk);
        check_eq("flush_req_dropped", 32'(bus_req_o), 32'd0);
        check_eq("flush_inst_data_kept", inst_data_o, 32'h00000013);
        check_eq("flush_no_resp", 32'(inst_q.size()), 32'd0);
        @(negedge clk);
        check_eq("flush_idle_no_req", 32'(bus_req_o), 32'd0);
        step();
        access("post_flush", 1'b1, 32'h108, 32'h55AA55AA, 0);

        // Watchdog expiry on a load with no ack.
        e0 = err_pulses;
        data_ce_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'hF; data_addr_i = 32'h300;
        data_q.push_back(32'h0);
        budget = 0;
        @(negedge clk);
        while (!bus_req_o && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check_eq("to_req_start", 32'(bus_req_o), 32'd1);
        for (int unsigned i = 1; i < TO; i++) begin
            @(negedge clk);
            check_eq("to_req_held", 32'(bus_req_o), 32'd1);
            check_eq("to_no_early_err", 32'(bus_err_o), 32'd0);
        end
        @(negedge clk);
        check_eq("to_req_cleared", 32'(bus_req_o), 32'd0);
        check_eq("to_err_pulse", 32'(bus_err_o), 32'd1);
        check_eq("to_err_addr", err_addr_o, 32'h300);
        #1 data_ce_i = 1'b0;
        @(negedge clk);
        check_eq("to_err_one_cycle", 32'(bus_err_o), 32'd0);
        check_eq("to_err_count", err_pulses - e0, 32'd1);
        check_eq("to_q_drained", 32'(data_q.size()), 32'd0);
        step();

        // Reset in DBUS clears everything on the same edge.
        data_ce_i = 1'b1; data_we_i = 1'b1; data_sel_i = 4'h3;
        data_addr_i = 32'h400; data_wdata_i = 32'hFACEFACE;
        @(negedge clk);
        @(negedge clk);
        check_eq("rstm_in_dbus", 32'(bus_req_o), 32'd1);
        #1;
        rst = 1'b0; data_ce_i = 1'b0; data_we_i = 1'b0;
        step();
        check_eq("rstm_bus_req", 32'(bus_req_o), 32'd0);
        check_eq("rstm_bus_we", 32'(bus_we_o), 32'd0);
        check_eq("rstm_bus_sel", 32'(bus_sel_o), 32'd0);
        check_eq("rstm_bus_addr", bus_addr_o, 32'h0);
        check_eq("rstm_bus_wdata", bus_wdata_o, 32'h0);
        check_eq("rstm_err_addr", err_addr_o, 32'h0);
        check_eq("rstm_data_rdata", data_rdata_o, 32'h0);
        check_eq("rstm_inst_data", inst_data_o, 32'h0);
        rst = 1'b1;
        step();
        access("fetch_after_rst", 1'b0, 32'h40, 32'h0BADF00D, 1);
    endtask

    initial begin
        fork
            monitor();
            run_tests();
            begin
                #100us;
                $display("FAIL global_timeout: simulation time limit reached");
                $fatal(1, "time limit");
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
